// File: rtl/hwpe_periph_rr_arbiter_if.sv
// Bundle of the initiator-side and target-side peripheral signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric.
interface hwpe_periph_rr_arbiter_if #(
  parameter int NB_MASTERS = 4,
  parameter int ID_WIDTH   = 2
);
  localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  logic [NB_MASTERS-1:0]          mst_req_i;
  logic [NB_MASTERS-1:0]          mst_gnt_o;
  logic [NB_MASTERS*32-1:0]       mst_add_i;
  logic [NB_MASTERS*32-1:0]       mst_data_i;
  logic [NB_MASTERS-1:0]          mst_wen_i;
  logic [NB_MASTERS*4-1:0]        mst_be_i;
  logic [NB_MASTERS*ID_WIDTH-1:0] mst_id_i;
  logic [NB_MASTERS-1:0]          mst_r_valid_o;
  logic [31:0]                    mst_r_data_o;
  logic [ID_WIDTH-1:0]            mst_r_id_o;

  logic                           slv_req_o;
  logic [31:0]                    slv_add_o;
  logic                           slv_wen_o;
  logic [3:0]                     slv_be_o;
  logic [31:0]                    slv_data_o;
  logic [ID_WIDTH+IDX_W-1:0]      slv_id_o;
  logic                           slv_gnt_i;
  logic                           slv_r_valid_i;
  logic [31:0]                    slv_r_data_i;
  logic [ID_WIDTH+IDX_W-1:0]      slv_r_id_i;
  logic                           resp_err_o;

  modport slave (
    input  mst_req_i, mst_add_i, mst_data_i, mst_wen_i, mst_be_i, mst_id_i,
    input  slv_gnt_i, slv_r_valid_i, slv_r_data_i, slv_r_id_i,
    output mst_gnt_o, mst_r_valid_o, mst_r_data_o, mst_r_id_o,
    output slv_req_o, slv_add_o, slv_wen_o, slv_be_o, slv_data_o, slv_id_o, resp_err_o
  );

  modport master (
    output mst_req_i, mst_add_i, mst_data_i, mst_wen_i, mst_be_i, mst_id_i,
    output slv_gnt_i, slv_r_valid_i, slv_r_data_i, slv_r_id_i,
    input  mst_gnt_o, mst_r_valid_o, mst_r_data_o, mst_r_id_o,
    input  slv_req_o, slv_add_o, slv_wen_o, slv_be_o, slv_data_o, slv_id_o, resp_err_o
  );
endinterface

// File: rtl/hwpe_periph_rr_arbiter.sv
// Round-robin arbiter sharing one HWPE peripheral target among NB_MASTERS initiators.
// state | meaning
// IDLE  | arbitrate among requesters each cycle, grant on slv_gnt_i
// HOLD  | winner stalled by target; drive its request until granted or withdrawn
module hwpe_periph_rr_arbiter #(
  parameter int NB_MASTERS = 4,
  parameter int ID_WIDTH   = 2
) (
  input logic clk_i,
  input logic rst_i,
  hwpe_periph_rr_arbiter_if.slave bus
);
  localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int IDX_N = 1 << IDX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]            state_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      lock_idx_q;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic                  win_found;
  logic                  sel_valid;
  int                    cand;

  logic [IDX_N-1:0]      idx_ok;
  logic [IDX_W-1:0]      r_idx;
  logic [NB_MASTERS-1:0] r_valid_q;
  logic [31:0]           r_data_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic                  err_q;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) >= NB_MASTERS - 1) ? '0 : i + 1'b1;
  endfunction

  // Scan from the farthest candidate down so the one closest to rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = NB_MASTERS - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k) % NB_MASTERS;
      if (bus.mst_req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    sel_idx   = (state_q == HOLD) ? lock_idx_q : win_idx;
    sel_valid = !rst_i && ((state_q == HOLD) ? bus.mst_req_i[lock_idx_q] : win_found);
  end

  always_comb begin
    bus.slv_req_o  = sel_valid;
    bus.slv_add_o  = '0;
    bus.slv_wen_o  = 1'b0;
    bus.slv_be_o   = '0;
    bus.slv_data_o = '0;
    bus.slv_id_o   = '0;
    bus.mst_gnt_o  = '0;
    if (sel_valid) begin
      bus.slv_add_o          = bus.mst_add_i[32*sel_idx +: 32];
      bus.slv_data_o         = bus.mst_data_i[32*sel_idx +: 32];
      bus.slv_wen_o          = bus.mst_wen_i[sel_idx];
      bus.slv_be_o           = bus.mst_be_i[4*sel_idx +: 4];
      bus.slv_id_o           = {sel_idx, bus.mst_id_i[ID_WIDTH*sel_idx +: ID_WIDTH]};
      bus.mst_gnt_o[sel_idx] = bus.slv_gnt_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else if (state_q == IDLE) begin
      if (win_found) begin
        if (bus.slv_gnt_i) begin
          rr_ptr_q <= next_idx(win_idx);
        end else begin
          lock_idx_q <= win_idx;
          state_q    <= HOLD;
        end
      end
    end else begin
      // A locked master withdrawing its request releases the lock without a grant.
      if (!bus.mst_req_i[lock_idx_q]) begin
        state_q <= IDLE;
      end else if (bus.slv_gnt_i) begin
        rr_ptr_q <= next_idx(lock_idx_q);
        state_q  <= IDLE;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < IDX_N; i++) idx_ok[i] = (i < NB_MASTERS);
  end

  assign r_idx = bus.slv_r_id_i[ID_WIDTH +: IDX_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
      r_id_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      r_valid_q <= '0;
      if (bus.slv_r_valid_i) begin
        if (idx_ok[r_idx]) begin
          r_valid_q[r_idx] <= 1'b1;
          r_data_q         <= bus.slv_r_data_i;
          r_id_q           <= bus.slv_r_id_i[ID_WIDTH-1:0];
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.mst_r_valid_o = r_valid_q;
  assign bus.mst_r_data_o  = r_data_q;
  assign bus.mst_r_id_o    = r_id_q;
  assign bus.resp_err_o    = err_q;
endmodule

// File: tb/tb_hwpe_periph_rr_arbiter.sv
// Randomized bench for the round-robin peripheral arbiter, 4-master and 3-master instances,
// checked against a rule-level model of priority rotation, locking and response routing.
module tb_hwpe_periph_rr_arbiter;
  logic clk;
  logic rst;

  hwpe_periph_rr_arbiter_if #(.NB_MASTERS(4), .ID_WIDTH(2)) b4 ();
  hwpe_periph_rr_arbiter_if #(.NB_MASTERS(3), .ID_WIDTH(2)) b3 ();

  hwpe_periph_rr_arbiter #(.NB_MASTERS(4), .ID_WIDTH(2)) u4 (.clk_i(clk), .rst_i(rst), .bus(b4));
  hwpe_periph_rr_arbiter #(.NB_MASTERS(3), .ID_WIDTH(2)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic [3:0]  req, wen;
  logic [31:0] add [4];
  logic [31:0] wdat[4];
  logic [3:0]  be  [4];
  logic [1:0]  id  [4];
  logic        gnt, rv;
  logic [31:0] rdata;
  logic [3:0]  rid;

  // model
  int          nm [2] = '{4, 3};
  int          prio  [2];
  int          locked[2];
  int          sel   [2];
  logic [3:0]  e_rv   [2];
  logic [31:0] e_rdata[2];
  logic [1:0]  e_rid  [2];
  logic        e_err  [2];

  int errors = 0;
  int checks = 0;
  logic [3:0]  last_gnt4;
  logic [31:0] last_add4;
  logic [3:0]  last_id4;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bus();
    b4.mst_req_i  = req;
    b4.mst_wen_i  = wen;
    b4.mst_add_i  = {add[3], add[2], add[1], add[0]};
    b4.mst_data_i = {wdat[3], wdat[2], wdat[1], wdat[0]};
    b4.mst_be_i   = {be[3], be[2], be[1], be[0]};
    b4.mst_id_i   = {id[3], id[2], id[1], id[0]};
    b3.mst_req_i  = req[2:0];
    b3.mst_wen_i  = wen[2:0];
    b3.mst_add_i  = {add[2], add[1], add[0]};
    b3.mst_data_i = {wdat[2], wdat[1], wdat[0]};
    b3.mst_be_i   = {be[2], be[1], be[0]};
    b3.mst_id_i   = {id[2], id[1], id[0]};
    b4.slv_gnt_i = gnt;  b4.slv_r_valid_i = rv;  b4.slv_r_data_i = rdata;  b4.slv_r_id_i = rid;
    b3.slv_gnt_i = gnt;  b3.slv_r_valid_i = rv;  b3.slv_r_data_i = rdata;  b3.slv_r_id_i = rid;
  endtask

  task automatic model_reset(input int k);
    prio[k] = 0;  locked[k] = -1;
    e_rv[k] = '0; e_rdata[k] = '0; e_rid[k] = '0; e_err[k] = 1'b0;
  endtask

  // Serviced master: the locked one if still requesting, else the requester nearest after prio.
  task automatic model_comb(input int k);
    sel[k] = -1;
    if (rst) return;
    if (locked[k] >= 0) begin
      if (req[locked[k]]) sel[k] = locked[k];
    end else begin
      for (int d = 0; d < nm[k]; d++) begin
        int m;
        m = (prio[k] + d) % nm[k];
        if (sel[k] < 0 && req[m]) sel[k] = m;
      end
    end
  endtask

  task automatic model_seq(input int k);
    int ridx;
    if (rst) begin model_reset(k); return; end
    if (locked[k] >= 0) begin
      if (sel[k] < 0) locked[k] = -1;
      else if (gnt) begin prio[k] = (locked[k] + 1) % nm[k]; locked[k] = -1; end
    end else if (sel[k] >= 0) begin
      if (gnt) prio[k] = (sel[k] + 1) % nm[k];
      else locked[k] = sel[k];
    end
    ridx = int'(rid[3:2]);
    e_rv[k] = '0;
    if (rv) begin
      if (ridx < nm[k]) begin
        e_rv[k] = 4'(1 << ridx); e_rdata[k] = rdata; e_rid[k] = rid[1:0];
      end else e_err[k] = 1'b1;
    end
  endtask

  task automatic check_inst(input int k);
    logic        g_req, g_wen, g_err;
    logic [31:0] g_add, g_dat, g_rdata;
    logic [3:0]  g_be, g_id, g_gnt, g_rv;
    logic [1:0]  g_rid;
    logic        x_req, x_wen;
    logic [31:0] x_add, x_dat;
    logic [3:0]  x_be, x_id, x_gnt;
    string       p;
    if (k == 0) begin
      g_req = b4.slv_req_o; g_wen = b4.slv_wen_o; g_add = b4.slv_add_o; g_dat = b4.slv_data_o;
      g_be = b4.slv_be_o; g_id = b4.slv_id_o; g_gnt = b4.mst_gnt_o; g_rv = b4.mst_r_valid_o;
      g_rdata = b4.mst_r_data_o; g_rid = b4.mst_r_id_o; g_err = b4.resp_err_o;
      last_gnt4 = g_gnt; last_add4 = g_add; last_id4 = g_id;
      p = "n4";
    end else begin
      g_req = b3.slv_req_o; g_wen = b3.slv_wen_o; g_add = b3.slv_add_o; g_dat = b3.slv_data_o;
      g_be = b3.slv_be_o; g_id = b3.slv_id_o; g_gnt = {1'b0, b3.mst_gnt_o};
      g_rv = {1'b0, b3.mst_r_valid_o};
      g_rdata = b3.mst_r_data_o; g_rid = b3.mst_r_id_o; g_err = b3.resp_err_o;
      p = "n3";
    end
    x_req = 1'b0; x_wen = 1'b0; x_add = '0; x_dat = '0; x_be = '0; x_id = '0; x_gnt = '0;
    if (sel[k] >= 0) begin
      x_req = 1'b1; x_wen = wen[sel[k]]; x_add = add[sel[k]]; x_dat = wdat[sel[k]];
      x_be = be[sel[k]]; x_id = {2'(sel[k]), id[sel[k]]};
      x_gnt = gnt ? 4'(1 << sel[k]) : 4'b0;
    end
    chk({p, "_slv_req"},  64'(g_req), 64'(x_req));
    chk({p, "_slv_add"},  64'(g_add), 64'(x_add));
    chk({p, "_slv_data"}, 64'(g_dat), 64'(x_dat));
    chk({p, "_slv_wen"},  64'(g_wen), 64'(x_wen));
    chk({p, "_slv_be"},   64'(g_be),  64'(x_be));
    chk({p, "_slv_id"},   64'(g_id),  64'(x_id));
    chk({p, "_gnt"},      64'(g_gnt), 64'(x_gnt));
    chk({p, "_r_valid"},  64'(g_rv),  64'(e_rv[k]));
    chk({p, "_r_data"},   64'(g_rdata), 64'(e_rdata[k]));
    chk({p, "_r_id"},     64'(g_rid), 64'(e_rid[k]));
    chk({p, "_resp_err"}, 64'(g_err), 64'(e_err[k]));
  endtask

  // Inputs applied just after a rising edge, checked mid-cycle, model advanced at the next edge.
  task automatic step();
    drive_bus();
    if (rst) begin model_reset(0); model_reset(1); end
    #2;
    for (int k = 0; k < 2; k++) begin model_comb(k); check_inst(k); end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_seq(k);
    #1;
  endtask

  task automatic randomize_fields();
    for (int m = 0; m < 4; m++) begin
      add[m] = $urandom; wdat[m] = $urandom; be[m] = 4'($urandom); id[m] = 2'($urandom);
    end
    wen = 4'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; gnt = 1'b0; rv = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; wen = '0; gnt = 1'b0; rv = 1'b0; rdata = '0; rid = '0;
    for (int m = 0; m < 4; m++) begin add[m] = '0; wdat[m] = '0; be[m] = '0; id[m] = '0; end
    model_reset(0); model_reset(1);
    @(posedge clk); #1;
    do_reset();

    // single master 2, two writes
    randomize_fields();
    req = 4'b0100; gnt = 1'b1; wen = 4'b0000; be[2] = 4'hF; id[2] = 2'd1; add[2] = 32'h10;
    step();
    chk("t1_gnt_a", 64'(last_gnt4), 64'h4);
    chk("t1_id_a",  64'(last_id4),  64'h9);
    add[2] = 32'h14;
    step();
    chk("t1_gnt_b", 64'(last_gnt4), 64'h4);
    chk("t1_add_b", 64'(last_add4), 64'h14);
    req = 4'b1111;
    step();
    chk("t1_ptr3", 64'(last_gnt4), 64'h8);

    // rotation from reset
    do_reset();
    req = 4'b1111; gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_rr", 64'(last_gnt4), 64'(1 << (i % 4)));
    end

    // stall and lock on master 1
    do_reset();
    randomize_fields();
    req = 4'b0010; gnt = 1'b0;
    step();
    req = 4'b0011;
    step(); chk("t3_hold_a", 64'(last_add4), 64'(add[1]));
    step(); chk("t3_hold_b", 64'(last_add4), 64'(add[1]));
    gnt = 1'b1;
    step(); chk("t3_gnt1", 64'(last_gnt4), 64'h2);
    req = 4'b0001;
    step(); chk("t3_gnt0", 64'(last_gnt4), 64'h1);

    // response to master 3 (out of range for the 3-master instance)
    req = '0; rv = 1'b1; rid = 4'b1101; rdata = 32'hDEADBEEF;
    step();
    chk("t4_rvalid", 64'(b4.mst_r_valid_o), 64'h8);
    chk("t4_rdata",  64'(b4.mst_r_data_o),  64'hDEADBEEF);
    chk("t4_rid",    64'(b4.mst_r_id_o),    64'h1);
    chk("t4_n3_rv",  64'(b3.mst_r_valid_o), 64'h0);
    chk("t4_n3_err", 64'(b3.resp_err_o),    64'h1);
    rv = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_err_sticky", 64'(b3.resp_err_o), 64'h1);

    // reset while master 2 is locked
    randomize_fields();
    req = 4'b0100; gnt = 1'b0;
    step();
    rst = 1'b1; req = 4'b0101;
    step();
    chk("t5_rst_req", 64'(b4.slv_req_o), 64'h0);
    chk("t5_rst_err", 64'(b3.resp_err_o), 64'h0);
    rst = 1'b0; gnt = 1'b1;
    step();
    chk("t5_after", 64'(last_gnt4), 64'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      randomize_fields();
      req   = 4'($urandom);
      gnt   = ($urandom_range(0, 3) != 0);
      rv    = 1'($urandom);
      rid   = 4'($urandom);
      rdata = $urandom;
      rst   = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
